// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator/decimator scheduling blocks.
//   sched_state_t      : scheduler FSM states
//   CIC_DATA_WIDTH     : default sample width, must match the CIC datapath
//   CIC_DEFAULT_RATIO  : default interpolation ratio
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    localparam int CIC_DATA_WIDTH    = 16;
    localparam int CIC_DEFAULT_RATIO = 64;

endpackage

// File: rtl/cic_phase_counter.sv
// Loadable wrap-around phase counter with terminal-count flag.
//   clk, rst   : clock, async active-high reset
//   load       : synchronous load of load_value (has priority over enable)
//   load_value : value loaded when load is high
//   enable     : advance the counter; wraps to 0 after period-1
//   period     : wrap period in clocks, must be >= 1
//   count      : current phase
//   tc         : high while count == period-1
module cic_phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == (period - WIDTH'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cic_interp_scheduler.sv
// Rate scheduler in front of the CIC3 interpolator. Takes samples from a
// valid/ready stream and emits one cic_valid strobe every period clocks,
// substituting zero (and counting it) on underrun, and flushing the
// interpolator with zeros when disabled.
//   clk, rst     : clock, async active-high reset
//   cfg_enable   : run request (level)
//   cfg_ratio    : interpolation period in clocks, 0 means 1; latched on start
//   s_data/s_valid/s_ready : upstream sample stream
//   cic_data/cic_valid     : registered sample + one-clock strobe to the CIC
//   underrun_cnt : saturating count of zero-substituted RUN strobes
//   busy         : high whenever the scheduler is not idle
//
// state | meaning
// IDLE  | stopped, waiting for cfg_enable
// PRIME | s_ready held high, waiting for the first sample (no underruns)
// RUN   | strobe at phase == period-1; sample or zero substitute
// DRAIN | strobes carry zero until FLUSH_SAMPLES have been issued
module cic_interp_scheduler
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH    = CIC_DATA_WIDTH,
    parameter int RATIO_W       = 8,
    parameter int FLUSH_SAMPLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_enable,
    input  logic [RATIO_W-1:0]           cfg_ratio,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic signed [DATA_WIDTH-1:0] cic_data,
    output logic                         cic_valid,
    output logic [CNT_W-1:0]             underrun_cnt,
    output logic                         busy
);

    localparam int FLUSH_W = $clog2(FLUSH_SAMPLES + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_SAMPLES - 1);

    sched_state_t state, state_next;

    logic [RATIO_W-1:0] period;
    logic [RATIO_W-1:0] phase;
    logic               phase_tc;
    logic               phase_load;
    logic               phase_run;
    logic [FLUSH_W-1:0] flush_cnt;

    logic                         start;
    logic                         strobe;
    logic signed [DATA_WIDTH-1:0] strobe_data;
    logic                         underrun;
    logic                         flush_clr;
    logic                         flush_inc;

    cic_phase_counter #(
        .WIDTH (RATIO_W)
    ) u_phase (
        .clk        (clk),
        .rst        (rst),
        .load       (phase_load),
        .load_value ('0),
        .enable     (phase_run),
        .period     (period),
        .count      (phase),
        .tc         (phase_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        s_ready     = 1'b0;
        start       = 1'b0;
        strobe      = 1'b0;
        strobe_data = '0;
        underrun    = 1'b0;
        flush_clr   = 1'b0;
        flush_inc   = 1'b0;
        phase_load  = 1'b0;
        phase_run   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                phase_load = 1'b1;
                if (cfg_enable) begin
                    start      = 1'b1;
                    state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                s_ready    = 1'b1;
                phase_load = 1'b1;
                // disable takes priority over a sample offered in the same cycle
                if (!cfg_enable) begin
                    state_next = ST_IDLE;
                end else if (s_valid) begin
                    strobe      = 1'b1;
                    strobe_data = s_data;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                phase_run = 1'b1;
                s_ready   = phase_tc;
                if (phase_tc) begin
                    strobe = 1'b1;
                    if (s_valid) begin
                        strobe_data = s_data;
                    end else begin
                        underrun = 1'b1;
                    end
                end
                if (!cfg_enable) begin
                    flush_clr  = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // phase keeps running so strobe spacing is unbroken across RUN->DRAIN
                phase_run = 1'b1;
                if (phase_tc) begin
                    strobe = 1'b1;
                    if (flush_cnt == FLUSH_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        flush_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period       <= RATIO_W'(1);
            cic_valid    <= 1'b0;
            cic_data     <= '0;
            underrun_cnt <= '0;
            flush_cnt    <= '0;
            busy         <= 1'b0;
        end else begin
            cic_valid <= strobe;
            if (strobe) begin
                cic_data <= strobe_data;
            end

            if (start) begin
                period       <= (cfg_ratio == '0) ? RATIO_W'(1) : cfg_ratio;
                underrun_cnt <= '0;
            end else if (underrun && (underrun_cnt != {CNT_W{1'b1}})) begin
                underrun_cnt <= underrun_cnt + CNT_W'(1);
            end

            if (start || flush_clr) begin
                flush_cnt <= '0;
            end else if (flush_inc) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end

            busy <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_cic_interp_scheduler.sv
// Self-checking bench for cic_interp_scheduler. A transaction-level model
// predicts each strobe from absolute cycle times (accept time + k*period)
// and is compared against the DUT every clock.
module tb_cic_interp_scheduler;
    import cic_pkg::*;

    localparam int DW   = 16;
    localparam int RW   = 8;
    localparam int FS   = 4;
    localparam int CW   = 2;
    localparam int UMAX = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en  = 1'b0;
    logic [RW-1:0]        ratio = '0;
    logic signed [DW-1:0] sd = '0;
    logic                 sv = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] cic_data;
    logic                 cic_valid;
    logic [CW-1:0]        ucnt;
    logic                 busy;

    always #5 clk = ~clk;

    cic_interp_scheduler #(
        .DATA_WIDTH    (DW),
        .RATIO_W       (RW),
        .FLUSH_SAMPLES (FS),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_enable   (en),
        .cfg_ratio    (ratio),
        .s_data       (sd),
        .s_valid      (sv),
        .s_ready      (s_ready),
        .cic_data     (cic_data),
        .cic_valid    (cic_valid),
        .underrun_cnt (ucnt),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;
    int n = 0;

    int                   m_mode;
    int                   m_period;
    int                   m_next;
    int                   m_flush;
    int                   m_ucnt;
    int                   m_runs;
    logic                 m_vld;
    logic signed [DW-1:0] m_dat;
    int                   next_sample = 1;
    bit                   src_random = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_period = 1;
        m_next   = 0;
        m_flush  = 0;
        m_ucnt   = 0;
        m_runs   = 0;
        m_vld    = 1'b0;
        m_dat    = '0;
    endtask

    function automatic bit third_run_strobe();
        return (m_mode == M_RUN) && (n == m_next) && (m_runs == 2);
    endfunction

    // One clock: predict, clock, compare. Inputs en/ratio are taken as set.
    task automatic step(input bit v);
        logic exp_ready;
        bit   accepted;
        accepted = 1'b0;
        sv = v;
        sd = next_sample[DW-1:0];
        #1;
        exp_ready = (m_mode == M_PRIME) || ((m_mode == M_RUN) && (n == m_next));
        chk("s_ready", {31'b0, s_ready}, {31'b0, exp_ready});
        m_vld = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (en) begin
                    m_mode   = M_PRIME;
                    m_period = (ratio == 0) ? 1 : int'(ratio);
                    m_ucnt   = 0;
                end
            end
            M_PRIME: begin
                if (!en) begin
                    m_mode = M_IDLE;
                end else if (sv) begin
                    m_vld    = 1'b1;
                    m_dat    = sd;
                    accepted = 1'b1;
                    m_next   = n + m_period;
                    m_runs   = 0;
                    m_mode   = M_RUN;
                end
            end
            M_RUN: begin
                if (n == m_next) begin
                    m_vld  = 1'b1;
                    m_runs++;
                    m_next += m_period;
                    if (sv) begin
                        m_dat    = sd;
                        accepted = 1'b1;
                    end else begin
                        m_dat = '0;
                        if (m_ucnt < UMAX) m_ucnt++;
                    end
                end
                if (!en) begin
                    m_mode  = M_DRAIN;
                    m_flush = FS;
                end
            end
            default: begin
                if (n == m_next) begin
                    m_vld  = 1'b1;
                    m_dat  = '0;
                    m_next += m_period;
                    m_flush--;
                    if (m_flush == 0) m_mode = M_IDLE;
                end
            end
        endcase
        if (accepted) begin
            if (src_random) next_sample = int'($urandom);
            else            next_sample++;
        end
        @(posedge clk);
        #1;
        n++;
        chk("cic_valid", {31'b0, cic_valid}, {31'b0, m_vld});
        chk("cic_data", cic_data, m_dat);
        chk("underrun_cnt", ucnt, m_ucnt);
        chk("busy", {31'b0, busy}, {31'b0, (m_mode != M_IDLE)});
    endtask

    task automatic finish_drain();
        en = 1'b0;
        for (int i = 0; i < 2000 && m_mode != M_IDLE; i++) step(1'b0);
        chk("drain_done_busy", {31'b0, busy}, 32'd0);
        step(1'b0);
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_cic_valid", {31'b0, cic_valid}, 32'd0);
        chk("rst_cic_data", cic_data, 32'd0);
        chk("rst_ucnt", ucnt, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        n++;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        step(1'b0);

        // 1: ratio 4, continuous stream 1,2,3...
        ratio = 8'd4;
        en = 1'b1;
        next_sample = 1;
        for (int i = 0; i < 20; i++) step(1'b1);
        chk("t1_ucnt", ucnt, 32'd0);
        finish_drain();

        // PRIME: disable together with a valid sample -> not accepted
        en = 1'b1;
        step(1'b0);
        en = 1'b0;
        step(1'b1);
        step(1'b1);
        chk("prime_abort_valid", {31'b0, cic_valid}, 32'd0);

        // 2: ratio 8, third RUN strobe starved
        ratio = 8'd8;
        en = 1'b1;
        step(1'b0);
        for (int i = 0; i < 45; i++) step(!third_run_strobe());
        chk("t2_ucnt", ucnt, 32'd1);

        // 3: disable mid-RUN, drain of zeros
        finish_drain();

        // 4: ratio 0 treated as 1
        ratio = 8'd0;
        en = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1);
        chk("t4_continuous", {31'b0, cic_valid}, 32'd1);
        finish_drain();

        // 5: reset mid-DRAIN, then restart
        ratio = 8'd4;
        en = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0);
        do_reset();
        ratio = 8'd3;
        en = 1'b1;
        step(1'b0);
        chk("t5_restart_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1);

        // 6: saturating underruns; ratio change during RUN is ignored
        for (int i = 0; i < 22; i++) begin
            if (i == 6) ratio = 8'd7;
            step(1'b0);
        end
        chk("t6_ucnt_sat", ucnt, 32'd3);
        for (int i = 0; i < 8; i++) step(1'b1);
        finish_drain();

        // default ratio, a few strobes
        ratio = RW'(CIC_DEFAULT_RATIO);
        en = 1'b1;
        for (int i = 0; i < 140; i++) step(1'b1);
        finish_drain();

        // randomized rounds
        src_random = 1'b1;
        next_sample = int'($urandom);
        for (int r = 0; r < 8; r++) begin
            ratio = RW'($urandom_range(0, 6));
            en = 1'b1;
            for (int i = 0; i < int'($urandom_range(10, 50)); i++)
                step($urandom_range(0, 9) < 7);
            en = 1'b0;
            for (int i = 0; i < 200 && m_mode != M_IDLE; i++) begin
                en = ($urandom_range(0, 3) == 0);
                step($urandom_range(0, 1) == 1);
            end
            en = 1'b0;
            chk("rand_idle_busy", {31'b0, busy}, 32'd0);
            step(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
